// File: rtl/eeg_wram_rdr.sv
// ---------------------------------------------------------------------------
// eeg_wram_rdr
//
// Weight-RAM burst reader. A configuration (base address, word count - 1)
// is accepted in IDLE. The block then issues one WRAM address request per
// word (ISSU), collects the returned words in a small first-word-fall-through
// FIFO, and streams them to the engine. After the last address has been
// accepted it waits (DRAN) until the word tagged "last" has left the FIFO,
// then returns to IDLE.
//
// Address issue is credit limited: requests still owed by the WRAM plus
// words already sitting in the FIFO never exceed FIFO_DEPTH, so every
// returned word always has a free slot. This is why DAT_RDY is tied high.
//
// Optional feature (compile-time macro EEG_WRAM_RDR_STRIDE_EN):
//   defined   -> extra input CFG_STRIDE, address increment = latched stride
//   undefined -> no CFG_STRIDE port, address increment = 1
//
// Parameters
//   ADD_AW      WRAM word-address width
//   DAT_DW      weight-data width
//   FIFO_DEPTH  output FIFO capacity and credit limit (power of two)
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   IS_IDLE                        high while the FSM is in IDLE
//   CFG_INFO_VLD/RDY               configuration handshake
//   CFG_BASE_ADD, CFG_LEN          first address, word count minus 1
//   CFG_STRIDE                     address increment (stride build only)
//   ADD_VLD/RDY/LST, ADD_ADD       WRAM address request channel
//   DAT_VLD/RDY/LST, DAT_DAT       WRAM data return channel
//   OUT_VLD/RDY/LST, OUT_DAT       engine output channel
// ---------------------------------------------------------------------------
module eeg_wram_rdr #(
    parameter int ADD_AW     = 13,
    parameter int DAT_DW     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,

    output logic              IS_IDLE,

    input  logic              CFG_INFO_VLD,
    output logic              CFG_INFO_RDY,
    input  logic [ADD_AW-1:0] CFG_BASE_ADD,
    input  logic [ADD_AW-1:0] CFG_LEN,
`ifdef EEG_WRAM_RDR_STRIDE_EN
    input  logic [ADD_AW-1:0] CFG_STRIDE,
`endif

    output logic              ADD_VLD,
    output logic              ADD_LST,
    input  logic              ADD_RDY,
    output logic [ADD_AW-1:0] ADD_ADD,

    input  logic              DAT_VLD,
    input  logic              DAT_LST,
    output logic              DAT_RDY,
    input  logic [DAT_DW-1:0] DAT_DAT,

    output logic              OUT_VLD,
    output logic              OUT_LST,
    input  logic              OUT_RDY,
    output logic [DAT_DW-1:0] OUT_DAT
);

    // FIFO pointer width (at least one bit) and counter width (holds 0..FIFO_DEPTH)
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ISSU = 2'd1,
        DRAN = 2'd2
    } state_t;

    // Pointer advance with explicit wrap, so a depth of 1 also works.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // Requests owed by the WRAM plus words held in the FIFO.
    function automatic logic [CW:0] credit_sum(input logic [CW-1:0] owed,
                                               input logic [CW-1:0] held);
        return {1'b0, owed} + {1'b0, held};
    endfunction

    state_t            state;
    logic              is_idle_q;
    logic              cfg_rdy_q;
    logic [ADD_AW-1:0] len_q;
    logic [ADD_AW-1:0] inc;

    // issue stage
    logic [ADD_AW-1:0] add_addr_p0;
    logic [ADD_AW-1:0] k_p0;
    logic              add_vld_p0;
    logic              add_lst_p0;

    // return stage
    logic [CW-1:0]     outst_p1;
    logic [CW-1:0]     occ_p1;
    logic [PW-1:0]     wr_ptr_p1;
    logic [PW-1:0]     rd_ptr_p1;
    logic [DAT_DW:0]   mem_p1 [FIFO_DEPTH];
    logic [CW:0]       credits;
    logic              vld_p1;
    logic              head_lst_p1;

    logic              cfg_hs;
    logic              add_hs;
    logic              push;
    logic              pop;

`ifdef EEG_WRAM_RDR_STRIDE_EN
    logic [ADD_AW-1:0] stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (cfg_hs) begin
            stride_q <= CFG_STRIDE;
        end
    end

    assign inc = stride_q;
`else
    assign inc = ADD_AW'(1);
`endif

    assign cfg_hs  = CFG_INFO_VLD & cfg_rdy_q;
    assign credits = credit_sum(outst_p1, occ_p1);

    // Only request while a returned word is guaranteed a FIFO slot.
    assign add_vld_p0 = (state == ISSU) && (credits < (CW+1)'(FIFO_DEPTH));
    assign add_lst_p0 = (state == ISSU) && (k_p0 == len_q);
    assign add_hs     = add_vld_p0 & ADD_RDY;

    assign push = DAT_VLD;
    assign pop  = vld_p1 & OUT_RDY;

    // ---- control FSM and issue stage -------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            is_idle_q   <= 1'b1;
            cfg_rdy_q   <= 1'b1;
            len_q       <= '0;
            add_addr_p0 <= '0;
            k_p0        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_hs) begin
                        state       <= ISSU;
                        is_idle_q   <= 1'b0;
                        cfg_rdy_q   <= 1'b0;
                        len_q       <= CFG_LEN;
                        add_addr_p0 <= CFG_BASE_ADD;
                        k_p0        <= '0;
                    end
                end
                ISSU: begin
                    // Address and index only move on an accepted request,
                    // which keeps ADD_ADD/ADD_LST steady under back-pressure.
                    if (add_hs) begin
                        add_addr_p0 <= add_addr_p0 + inc;
                        k_p0        <= k_p0 + ADD_AW'(1);
                        if (add_lst_p0) begin
                            state <= DRAN;
                        end
                    end
                end
                DRAN: begin
                    if (pop && head_lst_p1) begin
                        state     <= IDLE;
                        is_idle_q <= 1'b1;
                        cfg_rdy_q <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    is_idle_q <= 1'b1;
                    cfg_rdy_q <= 1'b1;
                end
            endcase
        end
    end

    // ---- return stage: credit counters and FIFO pointers -----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst_p1  <= '0;
            occ_p1    <= '0;
            wr_ptr_p1 <= '0;
            rd_ptr_p1 <= '0;
        end else begin
            case ({add_hs, push})
                2'b10:   outst_p1 <= outst_p1 + CW'(1);
                2'b01:   outst_p1 <= outst_p1 - CW'(1);
                default: outst_p1 <= outst_p1;
            endcase

            case ({push, pop})
                2'b10:   occ_p1 <= occ_p1 + CW'(1);
                2'b01:   occ_p1 <= occ_p1 - CW'(1);
                default: occ_p1 <= occ_p1;
            endcase

            if (push) begin
                wr_ptr_p1 <= ptr_inc(wr_ptr_p1);
            end
            if (pop) begin
                rd_ptr_p1 <= ptr_inc(rd_ptr_p1);
            end
        end
    end

    // FIFO storage carries the last flag alongside the data word.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_p1[wr_ptr_p1] <= {DAT_LST, DAT_DAT};
        end
    end

    // ---- output stage: first-word fall-through head ----------------------
    assign vld_p1                 = (occ_p1 != '0);
    assign {head_lst_p1, OUT_DAT} = mem_p1[rd_ptr_p1];

    assign OUT_VLD      = vld_p1;
    // Head storage is not reset, so the flag is qualified by valid.
    assign OUT_LST      = vld_p1 & head_lst_p1;

    assign ADD_VLD      = add_vld_p0;
    assign ADD_LST      = add_lst_p0;
    assign ADD_ADD      = add_addr_p0;

    assign DAT_RDY      = 1'b1;
    assign IS_IDLE      = is_idle_q;
    assign CFG_INFO_RDY = cfg_rdy_q;

endmodule
